core_pipe_exec_mdu: RTL and testbench

Parametrised iterative multiply/divide unit for the execute stage. It implements the RV64M/RV32M operations: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, plus the word forms when `word` is set. It sits beside the ALU, CFU and LSU. Its `ready` gates execute-stage progress, and its `result` feeds the execute writeback-data mux under the MDU writeback select. Multiply retires `MUL_UNROLL` bits per cycle; divide is radix-2 restoring.

---
 rtl/core_pipe_exec_mdu.sv | 237 +++++++++++++++++++++++
 tb/tb_core_pipe_exec_mdu.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/core_pipe_exec_mdu.sv
// core_pipe_exec_mdu: iterative RV64M/RV32M multiply/divide unit for the execute stage.
// Multiply is shift-add over a 2W-bit accumulator, MUL_UNROLL bits per cycle;
// divide is radix-2 restoring, one quotient bit per cycle. Signed operands are
// reduced to magnitudes on entry and the signs are re-applied when the result is read.
// Optional build macro CORE_MDU_ZERO_BYPASS_EN: zero-operand multiplies and
// zero-operand divides skip the iterations and complete in one cycle.
module core_pipe_exec_mdu #(
  parameter int XLEN       = 64,
  parameter int MUL_UNROLL = 1
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            valid,
  input  logic            new_instr,
  input  logic            flush,
  input  logic            op_mul,
  input  logic            op_mulh,
  input  logic            op_mulhsu,
  input  logic            op_mulhu,
  input  logic            op_div,
  input  logic            op_divu,
  input  logic            op_rem,
  input  logic            op_remu,
  input  logic            word,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            ready,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  typedef enum logic [1:0] {R_LO, R_HI, R_QUOT, R_REM} rsel_t;

  // Extends the low 32 bits of v to XLEN, sign-extending when sgn is set.
  function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] v, input logic sgn);
    logic [XLEN-1:0] r;
    r = v;
    for (int i = 32; i < XLEN; i++) r[i] = sgn & v[31];
    return r;
  endfunction

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [2*XLEN-1:0] acc_reg, acc_next;
  logic [2*XLEN-1:0] mcand_reg, mcand_next;
  logic [XLEN-1:0]   mplier_reg, mplier_next;
  logic [XLEN-1:0]   quot_reg, quot_next;
  logic [XLEN-1:0]   rem_reg, rem_next;
  logic [XLEN-1:0]   divisor_reg, divisor_next;
  logic              word_reg, word_next;
  rsel_t             rsel_reg, rsel_next;
  logic              neg_prod_reg, neg_prod_next;
  logic              neg_quot_reg, neg_quot_next;
  logic              neg_rem_reg, neg_rem_next;

  logic              is_mulh_any, is_mul, is_div, start, word_eff, bypass;
  logic              sgn1_op, sgn2_op, a_neg, b_neg;
  logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag;
  logic [CW-1:0]     cnt_load;
  rsel_t             rsel_load;

  logic [2*XLEN-1:0] mul_acc, mul_mc;
  logic [XLEN-1:0]   mul_mp;
  logic [XLEN:0]     rem_shift, rem_diff;
  logic              div_qbit;

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, res_raw;

  // Decode the op, pick the operand width and reduce signed operands to magnitudes.
  always_comb begin
    is_mulh_any = op_mulh | op_mulhsu | op_mulhu;
    is_mul      = op_mul | is_mulh_any;
    is_div      = op_div | op_divu | op_rem | op_remu;
    start       = valid & (is_mul | is_div) & ~flush;
    word_eff    = word & ~is_mulh_any;
    sgn1_op     = op_mulh | op_mulhsu | op_div | op_rem;
    sgn2_op     = op_mulh | op_div | op_rem;
    a_ext       = word_eff ? ext32(rs1, sgn1_op) : rs1;
    b_ext       = word_eff ? ext32(rs2, sgn2_op) : rs2;
    a_neg       = sgn1_op & a_ext[XLEN-1];
    b_neg       = sgn2_op & b_ext[XLEN-1];
    a_mag       = a_neg ? -a_ext : a_ext;
    b_mag       = b_neg ? -b_ext : b_ext;
    if (is_mul) cnt_load = word_eff ? CW'(32 / MUL_UNROLL) : CW'(XLEN / MUL_UNROLL);
    else        cnt_load = word_eff ? CW'(32) : CW'(XLEN);
    if (op_mul)           rsel_load = R_LO;
    else if (is_mulh_any) rsel_load = R_HI;
    else if (op_div | op_divu) rsel_load = R_QUOT;
    else                  rsel_load = R_REM;
`ifdef CORE_MDU_ZERO_BYPASS_EN
    bypass = (a_mag == '0) | (b_mag == '0);
`else
    bypass = 1'b0;
`endif
  end

  // One multiply iteration: MUL_UNROLL shift-add steps chained combinationally.
  always_comb begin
    mul_acc = acc_reg;
    mul_mc  = mcand_reg;
    mul_mp  = mplier_reg;
    for (int i = 0; i < MUL_UNROLL; i++) begin
      if (mul_mp[0]) mul_acc = mul_acc + mul_mc;
      mul_mc = mul_mc << 1;
      mul_mp = mul_mp >> 1;
    end
  end

  // One restoring divide step; the W+1-bit trial difference decides the quotient bit.
  always_comb begin
    rem_shift = {rem_reg, quot_reg[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, divisor_reg};
    div_qbit  = ~rem_diff[XLEN];
  end

  // State register.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) state_reg <= S_IDLE;
    else           state_reg <= state_next;
  end

  // Next-state logic; flush overrides everything else.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = bypass ? S_DONE : (is_mul ? S_MUL : S_DIV);
      S_MUL,
      S_DIV:   if (cnt_reg == CW'(1)) state_next = S_DONE;
      S_DONE:  if (new_instr) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (flush) state_next = S_IDLE;
  end

  // Datapath next values: load on accept, iterate while busy, hold otherwise.
  always_comb begin
    cnt_next      = cnt_reg;
    acc_next      = acc_reg;
    mcand_next    = mcand_reg;
    mplier_next   = mplier_reg;
    quot_next     = quot_reg;
    rem_next      = rem_reg;
    divisor_next  = divisor_reg;
    word_next     = word_reg;
    rsel_next     = rsel_reg;
    neg_prod_next = neg_prod_reg;
    neg_quot_next = neg_quot_reg;
    neg_rem_next  = neg_rem_reg;
    case (state_reg)
      S_IDLE: if (start) begin
        cnt_next      = cnt_load;
        acc_next      = '0;
        mcand_next    = {{XLEN{1'b0}}, a_mag};
        mplier_next   = b_mag;
        // Word dividends are left-aligned so the shift-out always starts at bit XLEN-1.
        quot_next     = word_eff ? (a_mag << (XLEN - 32)) : a_mag;
        rem_next      = '0;
        divisor_next  = b_mag;
        word_next     = word_eff;
        rsel_next     = rsel_load;
        neg_prod_next = a_neg ^ b_neg;
        neg_quot_next = (a_neg ^ b_neg) & (b_mag != '0);
        neg_rem_next  = a_neg;
`ifdef CORE_MDU_ZERO_BYPASS_EN
        // Preload what the full divide-by-zero iteration would have produced.
        if (is_div && (b_mag == '0)) begin
          quot_next = '1;
          rem_next  = a_mag;
        end
`endif
      end
      S_MUL: begin
        cnt_next    = cnt_reg - CW'(1);
        acc_next    = mul_acc;
        mcand_next  = mul_mc;
        mplier_next = mul_mp;
      end
      S_DIV: begin
        cnt_next  = cnt_reg - CW'(1);
        quot_next = {quot_reg[XLEN-2:0], div_qbit};
        rem_next  = div_qbit ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
      end
      default: ;
    endcase
  end

  // Datapath registers; reset clears everything so no stale value can leak out.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      cnt_reg      <= '0;
      acc_reg      <= '0;
      mcand_reg    <= '0;
      mplier_reg   <= '0;
      quot_reg     <= '0;
      rem_reg      <= '0;
      divisor_reg  <= '0;
      word_reg     <= 1'b0;
      rsel_reg     <= R_LO;
      neg_prod_reg <= 1'b0;
      neg_quot_reg <= 1'b0;
      neg_rem_reg  <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      acc_reg      <= acc_next;
      mcand_reg    <= mcand_next;
      mplier_reg   <= mplier_next;
      quot_reg     <= quot_next;
      rem_reg      <= rem_next;
      divisor_reg  <= divisor_next;
      word_reg     <= word_next;
      rsel_reg     <= rsel_next;
      neg_prod_reg <= neg_prod_next;
      neg_quot_reg <= neg_quot_next;
      neg_rem_reg  <= neg_rem_next;
    end
  end

  // Outputs: sign fix-up, result select, word sign-extension, zero when not ready.
  always_comb begin
    prod_fix = neg_prod_reg ? -acc_reg : acc_reg;
    quot_fix = neg_quot_reg ? -quot_reg : quot_reg;
    rem_fix  = neg_rem_reg ? -rem_reg : rem_reg;
    case (rsel_reg)
      R_LO:    res_raw = prod_fix[XLEN-1:0];
      R_HI:    res_raw = prod_fix[2*XLEN-1:XLEN];
      R_QUOT:  res_raw = quot_fix;
      default: res_raw = rem_fix;
    endcase
    if (word_reg) res_raw = ext32(res_raw, 1'b1);
    ready  = (state_reg == S_DONE);
    result = ready ? res_raw : '0;
  end

endmodule

// File: tb/tb_core_pipe_exec_mdu.sv
// Directed testbench for core_pipe_exec_mdu (XLEN=64, MUL_UNROLL=1 and 4).
module tb_core_pipe_exec_mdu;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        valid, new_instr, flush, word;
  logic        op_mul, op_mulh, op_mulhsu, op_mulhu, op_div, op_divu, op_rem, op_remu;
  logic [63:0] rs1, rs2;
  logic        ready, ready4;
  logic [63:0] result, result4;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef CORE_MDU_ZERO_BYPASS_EN
  localparam int ZCYC64 = 1;
  localparam int ZCYC32 = 1;
`else
  localparam int ZCYC64 = 65;
  localparam int ZCYC32 = 33;
`endif

  always #5 g_clk = ~g_clk;

  core_pipe_exec_mdu #(.XLEN(64), .MUL_UNROLL(1)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .valid(valid), .new_instr(new_instr), .flush(flush),
    .op_mul(op_mul), .op_mulh(op_mulh), .op_mulhsu(op_mulhsu), .op_mulhu(op_mulhu),
    .op_div(op_div), .op_divu(op_divu), .op_rem(op_rem), .op_remu(op_remu),
    .word(word), .rs1(rs1), .rs2(rs2), .ready(ready), .result(result)
  );

  core_pipe_exec_mdu #(.XLEN(64), .MUL_UNROLL(4)) dut4 (
    .g_clk(g_clk), .g_resetn(g_resetn), .valid(valid), .new_instr(new_instr), .flush(flush),
    .op_mul(op_mul), .op_mulh(op_mulh), .op_mulhsu(op_mulhsu), .op_mulhu(op_mulhu),
    .op_div(op_div), .op_divu(op_divu), .op_rem(op_rem), .op_remu(op_remu),
    .word(word), .rs1(rs1), .rs2(rs2), .ready(ready4), .result(result4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // op index: 0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu, other = none
  task automatic set_op(input int op);
    op_mul    = (op == 0);
    op_mulh   = (op == 1);
    op_mulhsu = (op == 2);
    op_mulhu  = (op == 3);
    op_div    = (op == 4);
    op_divu   = (op == 5);
    op_rem    = (op == 6);
    op_remu   = (op == 7);
  endtask

  // Counts cycles from the accepting edge (cycle 1) until ready; gives up at 200.
  task automatic wait_ready(input bit use4, output int cyc);
    cyc = 1;
    while (!(use4 ? ready4 : ready) && cyc < 200) begin
      @(posedge g_clk); #1;
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input int op, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_res, input int exp_cyc);
    int cyc;
    @(negedge g_clk);
    set_op(op); word = w; rs1 = a; rs2 = b; valid = 1'b1;
    @(posedge g_clk); #1;
    valid = 1'b0; set_op(-1);
    wait_ready(1'b0, cyc);
    $display("op %-16s cycles=%0d result=%h", tag, cyc, result);
    chk({tag, "_cyc"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, "_res"}, result, exp_res);
    @(negedge g_clk); new_instr = 1'b1;
    @(posedge g_clk); #1; new_instr = 1'b0;
    chk({tag, "_rdy_drop"}, 64'(ready), 64'(0));
  endtask

  initial begin
    int cyc;
    g_resetn = 1'b0; valid = 1'b0; new_instr = 1'b0; flush = 1'b0; word = 1'b0;
    rs1 = '0; rs2 = '0; set_op(-1);
    repeat (3) @(posedge g_clk);
    #1;
    chk("rst_ready", 64'(ready), 64'(0));
    chk("rst_result", result, 64'(0));
    chk("rst_ready4", 64'(ready4), 64'(0));
    chk("rst_result4", result4, 64'(0));
    @(negedge g_clk); g_resetn = 1'b1;

    run_op("mul_3_m5",    0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 65);
    run_op("mulhsu_m1_2", 2, 1'b0, ALL1, 64'd2, ALL1, 65);
    run_op("mulhu_m1_2",  3, 1'b0, ALL1, 64'd2, 64'd1, 65);
    run_op("mulh_min_sq", 1, 1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
           64'h4000_0000_0000_0000, 65);
    run_op("mulw_ovf",    0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33);
    run_op("div_ovf",     4, 1'b0, 64'h8000_0000_0000_0000, ALL1, 64'h8000_0000_0000_0000, 65);
    run_op("rem_ovf",     6, 1'b0, 64'h8000_0000_0000_0000, ALL1, 64'd0, 65);
    run_op("divu_100_7",  5, 1'b0, 64'd100, 64'd7, 64'd14, 65);
    run_op("remu_100_7",  7, 1'b0, 64'd100, 64'd7, 64'd2, 65);
    run_op("div_m100_7",  4, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65);
    run_op("rem_m100_7",  6, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run_op("divuw_by0",   5, 1'b1, 64'h0000_0001_0000_0007, 64'd0, ALL1, ZCYC32);
    run_op("remw_m7_2",   6, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ALL1, 33);
    run_op("div_m5_by0",  4, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, ALL1, ZCYC64);
    run_op("rem_m5_by0",  6, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, ZCYC64);
    run_op("mul_zero",    0, 1'b0, 64'd0, 64'd12345, 64'd0, ZCYC64);

    // valid without any op bit must not start anything
    @(negedge g_clk); rs1 = 64'd9; rs2 = 64'd9; set_op(-1); valid = 1'b1;
    @(posedge g_clk); #1; valid = 1'b0;
    repeat (3) @(posedge g_clk);
    #1;
    $display("op %-16s ready=%0d", "undef_op", ready);
    chk("undef_ready", 64'(ready), 64'(0));

    // flush at cycle 10 of a divide, then a multiply accepted from cycle 11
    @(negedge g_clk); set_op(4); word = 1'b0; rs1 = 64'd1000; rs2 = 64'd3; valid = 1'b1;
    @(posedge g_clk); #1; valid = 1'b0; set_op(-1);
    repeat (9) begin @(posedge g_clk); #1; end
    flush = 1'b1;
    @(posedge g_clk); #1; flush = 1'b0;
    $display("op %-16s ready=%0d", "div_flush", ready);
    chk("flush_ready", 64'(ready), 64'(0));
    run_op("mul_after_flush", 0, 1'b0, 64'd6, 64'd7, 64'd42, 65);

    // unroll-4 latency, then asynchronous reset in the middle of the unroll-1 multiply
    @(negedge g_clk); set_op(0); word = 1'b0; rs1 = 64'd3; rs2 = 64'hFFFF_FFFF_FFFF_FFFB; valid = 1'b1;
    @(posedge g_clk); #1; valid = 1'b0; set_op(-1);
    wait_ready(1'b1, cyc);
    $display("op %-16s cycles=%0d result=%h", "mul_u4", cyc, result4);
    chk("mul_u4_cyc", 64'(cyc), 64'(17));
    chk("mul_u4_res", result4, 64'hFFFF_FFFF_FFFF_FFF1);
    chk("mul_u1_busy", 64'(ready), 64'(0));
    repeat (3) @(posedge g_clk);
    @(negedge g_clk); #2; g_resetn = 1'b0; #1;
    $display("op %-16s ready=%0d ready4=%0d", "reset_mid_mul", ready, ready4);
    chk("arst_ready", 64'(ready), 64'(0));
    chk("arst_result", result, 64'(0));
    chk("arst_ready4", 64'(ready4), 64'(0));
    chk("arst_result4", result4, 64'(0));
    @(negedge g_clk); g_resetn = 1'b1;

    run_op("mulw_after_rst", 0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
